// File: rtl/counter_pkg.sv
// Shared types for the up/down modulo counter family.
// Holds the counting mode, the per-cycle direction and the direction decoder.
package counter_pkg;

  typedef enum logic {CNT_WRAP, CNT_SAT} cnt_mode_e;

  typedef enum logic [1:0] {DIR_HOLD, DIR_UP, DIR_DOWN} cnt_dir_e;

  // Disabled, idle, or conflicting up+down requests all collapse to hold.
  function automatic cnt_dir_e dir_decode(input logic en, input logic up, input logic down);
    cnt_dir_e d;
    d = DIR_HOLD;
    if (en && (up != down)) d = up ? DIR_UP : DIR_DOWN;
    return d;
  endfunction

endpackage

// File: rtl/counter_next_calc.sv
// Combinational next-count calculator for a modulo (max+1) counter.
// Handles step up/down, wrap vs saturate, and folding of an out-of-range count.
// All arithmetic runs one bit wider than the widest operand, so nothing truncates
// before the result has been clamped back into 0..max.
module counter_next_calc
  import counter_pkg::*;
#(
  parameter int WIDTH_P      = 8,
  parameter int STEP_WIDTH_P = 4
) (
  input  logic [WIDTH_P-1:0]      cur_count,
  input  cnt_dir_e                dir,
  input  logic [STEP_WIDTH_P-1:0] step,
  input  logic [WIDTH_P-1:0]      max_val,
  input  cnt_mode_e               mode,
  output logic [WIDTH_P-1:0]      nxt_count,
  output logic                    evt
);

  localparam int AW = ((STEP_WIDTH_P > WIDTH_P) ? STEP_WIDTH_P : WIDTH_P) + 1;

  logic [AW-1:0] c_w, m_w, s_w;
  logic [AW-1:0] up_sum, up_wrap, dn_sub, dn_lift, dn_wrap;

  assign c_w     = AW'(cur_count);
  assign m_w     = AW'(max_val);
  assign s_w     = AW'(step);
  assign up_sum  = c_w + s_w;
  assign up_wrap = up_sum - (m_w + AW'(1));   // only used when up_sum > max
  assign dn_sub  = c_w - s_w;                 // only used when step <= count
  assign dn_lift = c_w + m_w + AW'(1);        // count shifted up by one modulus
  assign dn_wrap = dn_lift - s_w;             // only used when dn_lift >= step

  // Select the next count and whether this update wrapped or saturated.
  always_comb begin
    nxt_count = cur_count;
    evt       = 1'b0;
    if (dir != DIR_HOLD && c_w > m_w) begin
      // max was lowered below the live count: fold back into range
      nxt_count = (mode == CNT_SAT) ? max_val : '0;
      evt       = 1'b1;
    end else if (dir == DIR_UP) begin
      if (up_sum <= m_w) begin
        nxt_count = up_sum[WIDTH_P-1:0];
      end else if (mode == CNT_WRAP) begin
        // a step larger than the modulus can still land past max
        nxt_count = (up_wrap > m_w) ? max_val : up_wrap[WIDTH_P-1:0];
        evt       = 1'b1;
      end else begin
        nxt_count = max_val;
        evt       = (cur_count != max_val);
      end
    end else if (dir == DIR_DOWN) begin
      if (s_w <= c_w) begin
        nxt_count = dn_sub[WIDTH_P-1:0];
      end else if (mode == CNT_WRAP) begin
        nxt_count = (dn_lift < s_w) ? '0 : dn_wrap[WIDTH_P-1:0];
        evt       = 1'b1;
      end else begin
        nxt_count = '0;
        evt       = (cur_count != '0);
      end
    end
  end

endmodule

// File: rtl/counter_updown_mod.sv
// Up/down modulo counter with programmable terminal value, variable step,
// synchronous load, wrap or saturate mode and a registered event pulse.
// Optional sticky overflow/underflow flags: define COUNTER_UPDOWN_MOD_STICKY_EN.
module counter_updown_mod
  import counter_pkg::*;
#(
  parameter int WIDTH_P      = 8,
  parameter int RESET_VAL    = 0,
  parameter int STEP_WIDTH_P = 4,
  parameter int SATURATE_P   = 0
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    en_i,
  input  logic                    up_i,
  input  logic                    down_i,
  input  logic [STEP_WIDTH_P-1:0] step_i,
  input  logic                    load_i,
  input  logic [WIDTH_P-1:0]      load_val_i,
  input  logic [WIDTH_P-1:0]      max_i,
`ifdef COUNTER_UPDOWN_MOD_STICKY_EN
  input  logic                    clear_i,
  output logic                    ovf_o,
  output logic                    unf_o,
`endif
  output logic [WIDTH_P-1:0]      count_o,
  output logic                    at_max_o,
  output logic                    at_zero_o,
  output logic                    event_o
);

  localparam cnt_mode_e MODE = (SATURATE_P != 0) ? CNT_SAT : CNT_WRAP;

  logic [WIDTH_P-1:0] count_r, calc_nxt;
  logic               event_r, calc_evt;
  cnt_dir_e           dir;

  assign dir = dir_decode(en_i, up_i, down_i);

  counter_next_calc #(
    .WIDTH_P      (WIDTH_P),
    .STEP_WIDTH_P (STEP_WIDTH_P)
  ) u_calc (
    .cur_count (count_r),
    .dir       (dir),
    .step      (step_i),
    .max_val   (max_i),
    .mode      (MODE),
    .nxt_count (calc_nxt),
    .evt       (calc_evt)
  );

  // Count register: reset beats load, load beats counting; load clamps to max.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_r <= WIDTH_P'(RESET_VAL);
      event_r <= 1'b0;
    end else if (load_i) begin
      count_r <= (load_val_i > max_i) ? max_i : load_val_i;
      event_r <= 1'b0;
    end else begin
      count_r <= calc_nxt;
      event_r <= calc_evt;
    end
  end

  assign count_o   = count_r;
  assign event_o   = event_r;
  assign at_max_o  = (count_r == max_i);
  assign at_zero_o = (count_r == '0);

`ifdef COUNTER_UPDOWN_MOD_STICKY_EN
  logic ovf_r, unf_r, ovf_set, unf_set;

  // a load suppresses counting, so it can never raise a sticky flag
  assign ovf_set = !load_i && calc_evt && (dir == DIR_UP);
  assign unf_set = !load_i && calc_evt && (dir == DIR_DOWN);

  // Sticky flags: a new event in the same cycle as clear keeps the flag set.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ovf_r <= 1'b0;
      unf_r <= 1'b0;
    end else begin
      ovf_r <= ovf_set | (ovf_r & ~clear_i);
      unf_r <= unf_set | (unf_r & ~clear_i);
    end
  end

  assign ovf_o = ovf_r;
  assign unf_o = unf_r;
`endif

endmodule

// File: tb/tb_counter_updown_mod.sv
// Bench for counter_updown_mod: one wrap-mode and one saturate-mode instance
// share all inputs and are compared against an integer reference model.
module tb_counter_updown_mod;

  logic       clk_i = 1'b0;
  logic       reset_i, en_i, up_i, down_i, load_i, clear_i;
  logic [3:0] step_i;
  logic [7:0] load_val_i, max_i;

  logic [7:0] cnt_o   [2];
  logic       evt_o   [2];
  logic       amax_o  [2];
  logic       azero_o [2];
  logic       ovf_o   [2];
  logic       unf_o   [2];

  int m_cnt [2];
  int m_evt [2];
  int m_ovf [2];
  int m_unf [2];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk_i = ~clk_i;

  counter_updown_mod #(.WIDTH_P(8), .RESET_VAL(5), .STEP_WIDTH_P(4), .SATURATE_P(0)) u_wrap (
    .clk_i(clk_i), .reset_i(reset_i), .en_i(en_i), .up_i(up_i), .down_i(down_i),
    .step_i(step_i), .load_i(load_i), .load_val_i(load_val_i), .max_i(max_i),
`ifdef COUNTER_UPDOWN_MOD_STICKY_EN
    .clear_i(clear_i), .ovf_o(ovf_o[0]), .unf_o(unf_o[0]),
`endif
    .count_o(cnt_o[0]), .at_max_o(amax_o[0]), .at_zero_o(azero_o[0]), .event_o(evt_o[0]));

  counter_updown_mod #(.WIDTH_P(8), .RESET_VAL(5), .STEP_WIDTH_P(4), .SATURATE_P(1)) u_sat (
    .clk_i(clk_i), .reset_i(reset_i), .en_i(en_i), .up_i(up_i), .down_i(down_i),
    .step_i(step_i), .load_i(load_i), .load_val_i(load_val_i), .max_i(max_i),
`ifdef COUNTER_UPDOWN_MOD_STICKY_EN
    .clear_i(clear_i), .ovf_o(ovf_o[1]), .unf_o(unf_o[1]),
`endif
    .count_o(cnt_o[1]), .at_max_o(amax_o[1]), .at_zero_o(azero_o[1]), .event_o(evt_o[1]));

`ifndef COUNTER_UPDOWN_MOD_STICKY_EN
  assign ovf_o[0] = 1'b0; assign ovf_o[1] = 1'b0;
  assign unf_o[0] = 1'b0; assign unf_o[1] = 1'b0;
`endif

  // Reference: modulus arithmetic on plain integers (m=0 wrap, m=1 saturate).
  task automatic model_step(input int m);
    int c, mx, st, n, e, going_up, going_dn;
    c = m_cnt[m]; mx = int'(max_i); st = int'(step_i);
    n = c; e = 0; going_up = 0; going_dn = 0;
    if (reset_i) begin
      m_cnt[m] = 5; m_evt[m] = 0; m_ovf[m] = 0; m_unf[m] = 0;
      return;
    end
    if (load_i) begin
      n = (int'(load_val_i) > mx) ? mx : int'(load_val_i);
    end else if (en_i && (up_i != down_i)) begin
      going_up = up_i; going_dn = down_i;
      if (c > mx) begin
        n = m ? mx : 0; e = 1;
      end else if (up_i) begin
        if (c + st <= mx) n = c + st;
        else if (m == 0) begin n = (c + st) - (mx + 1); if (n > mx) n = mx; e = 1; end
        else begin n = mx; e = (c != mx); end
      end else begin
        if (st <= c) n = c - st;
        else if (m == 0) begin n = c + mx + 1 - st; if (n < 0) n = 0; e = 1; end
        else begin n = 0; e = (c != 0); end
      end
    end
    m_cnt[m] = n; m_evt[m] = e;
    m_ovf[m] = (e && going_up) ? 1 : (clear_i ? 0 : m_ovf[m]);
    m_unf[m] = (e && going_dn) ? 1 : (clear_i ? 0 : m_unf[m]);
  endtask

  task automatic tick();
    model_step(0); model_step(1);
    @(posedge clk_i); #1;
  endtask

  task automatic idle();
    reset_i = 0; en_i = 0; up_i = 0; down_i = 0; load_i = 0; clear_i = 0;
    step_i = 0; load_val_i = 0;
  endtask

  task automatic do_load(input int v);
    idle(); load_i = 1; load_val_i = 8'(v); tick(); load_i = 0;
  endtask

  task automatic test_reset();
    idle(); reset_i = 1; max_i = 9; tick(); reset_i = 0;
    n_chk++; if (cnt_o[0] !== 8'd5) begin n_fail++; $display("FAIL reset_cnt: got %0d expected 5", cnt_o[0]); end
    n_chk++; if (evt_o[0] !== 1'b0) begin n_fail++; $display("FAIL reset_evt: got %b expected 0", evt_o[0]); end
    n_chk++; if (azero_o[0] !== 1'b0) begin n_fail++; $display("FAIL reset_zero: got %b expected 0", azero_o[0]); end
    n_chk++; if (cnt_o[1] !== 8'd5) begin n_fail++; $display("FAIL reset_cnt_sat: got %0d expected 5", cnt_o[1]); end
    up_i = 1; step_i = 3;   // en_i stays low, so this must not count
    for (int i = 0; i < 3; i++) begin
      tick();
      n_chk++; if (cnt_o[0] !== 8'd5 || evt_o[0] !== 1'b0) begin n_fail++; $display("FAIL hold_en0: got %0d/%b expected 5/0", cnt_o[0], evt_o[0]); end
    end
  endtask

  task automatic test_wrap();
    max_i = 9; do_load(8);
    en_i = 1; up_i = 1; step_i = 3; tick();
    n_chk++; if (cnt_o[0] !== 8'd1 || evt_o[0] !== 1'b1) begin n_fail++; $display("FAIL wrap_up: got %0d/%b expected 1/1", cnt_o[0], evt_o[0]); end
    n_chk++; if (cnt_o[1] !== 8'd9 || evt_o[1] !== 1'b1) begin n_fail++; $display("FAIL sat_up: got %0d/%b expected 9/1", cnt_o[1], evt_o[1]); end
    step_i = 1; tick();
    n_chk++; if (cnt_o[0] !== 8'd2 || evt_o[0] !== 1'b0) begin n_fail++; $display("FAIL wrap_next: got %0d/%b expected 2/0", cnt_o[0], evt_o[0]); end
    n_chk++; if (cnt_o[1] !== 8'd9 || evt_o[1] !== 1'b0 || amax_o[1] !== 1'b1) begin n_fail++; $display("FAIL sat_at_max: got %0d/%b/%b expected 9/0/1", cnt_o[1], evt_o[1], amax_o[1]); end
  endtask

  task automatic test_saturate();
    max_i = 9; do_load(1);
    en_i = 1; down_i = 1; step_i = 4; tick();
    n_chk++; if (cnt_o[1] !== 8'd0 || evt_o[1] !== 1'b1) begin n_fail++; $display("FAIL sat_dn: got %0d/%b expected 0/1", cnt_o[1], evt_o[1]); end
    n_chk++; if (cnt_o[0] !== 8'd7 || evt_o[0] !== 1'b1) begin n_fail++; $display("FAIL wrap_dn: got %0d/%b expected 7/1", cnt_o[0], evt_o[0]); end
    tick();
    n_chk++; if (cnt_o[1] !== 8'd0 || evt_o[1] !== 1'b0 || azero_o[1] !== 1'b1) begin n_fail++; $display("FAIL sat_dn2: got %0d/%b/%b expected 0/0/1", cnt_o[1], evt_o[1], azero_o[1]); end
    n_chk++; if (cnt_o[0] !== 8'd3 || evt_o[0] !== 1'b0) begin n_fail++; $display("FAIL wrap_dn2: got %0d/%b expected 3/0", cnt_o[0], evt_o[0]); end
  endtask

  task automatic test_load();
    idle(); max_i = 50; load_i = 1; load_val_i = 200; up_i = 1; step_i = 2; tick();
    for (int m = 0; m < 2; m++) begin
      n_chk++; if (cnt_o[m] !== 8'd50 || amax_o[m] !== 1'b1 || evt_o[m] !== 1'b0) begin n_fail++; $display("FAIL load_clamp[%0d]: got %0d/%b/%b expected 50/1/0", m, cnt_o[m], amax_o[m], evt_o[m]); end
    end
  endtask

  task automatic test_fold();
    max_i = 9; do_load(7);
    max_i = 3; en_i = 1; up_i = 1; step_i = 1; tick();
    n_chk++; if (cnt_o[0] !== 8'd0 || evt_o[0] !== 1'b1) begin n_fail++; $display("FAIL fold_wrap: got %0d/%b expected 0/1", cnt_o[0], evt_o[0]); end
    n_chk++; if (cnt_o[1] !== 8'd3 || evt_o[1] !== 1'b1) begin n_fail++; $display("FAIL fold_sat: got %0d/%b expected 3/1", cnt_o[1], evt_o[1]); end
    down_i = 1; tick();
    n_chk++; if (cnt_o[0] !== 8'd0 || evt_o[0] !== 1'b0 || cnt_o[1] !== 8'd3) begin n_fail++; $display("FAIL updown_hold: got %0d/%b/%0d expected 0/0/3", cnt_o[0], evt_o[0], cnt_o[1]); end
    reset_i = 1; load_i = 1; load_val_i = 2; max_i = 9; tick(); idle();
    n_chk++; if (cnt_o[0] !== 8'd5 || cnt_o[1] !== 8'd5) begin n_fail++; $display("FAIL reset_over_load: got %0d/%0d expected 5/5", cnt_o[0], cnt_o[1]); end
  endtask

  task automatic test_max_zero();
    max_i = 0; do_load(0);
    en_i = 1;
    for (int i = 0; i < 3; i++) begin
      up_i = (i != 2); down_i = (i == 2); step_i = 4'(i + 2); tick();
      n_chk++; if (cnt_o[0] !== 8'd0 || evt_o[0] !== 1'b1) begin n_fail++; $display("FAIL max0_wrap: got %0d/%b expected 0/1", cnt_o[0], evt_o[0]); end
      n_chk++; if (cnt_o[1] !== 8'd0 || evt_o[1] !== 1'b0) begin n_fail++; $display("FAIL max0_sat: got %0d/%b expected 0/0", cnt_o[1], evt_o[1]); end
    end
  endtask

  task automatic test_sticky();
`ifdef COUNTER_UPDOWN_MOD_STICKY_EN
    idle(); reset_i = 1; max_i = 9; tick(); reset_i = 0;
    en_i = 1; up_i = 1; step_i = 7; tick();
    n_chk++; if (cnt_o[0] !== 8'd2 || ovf_o[0] !== 1'b1 || unf_o[0] !== 1'b0) begin n_fail++; $display("FAIL sticky_ovf: got %0d/%b/%b expected 2/1/0", cnt_o[0], ovf_o[0], unf_o[0]); end
    up_i = 0; down_i = 1; step_i = 5; clear_i = 1; tick();
    n_chk++; if (cnt_o[0] !== 8'd7 || ovf_o[0] !== 1'b0 || unf_o[0] !== 1'b1) begin n_fail++; $display("FAIL sticky_unf: got %0d/%b/%b expected 7/0/1", cnt_o[0], ovf_o[0], unf_o[0]); end
    idle(); tick();
    n_chk++; if (unf_o[0] !== 1'b1) begin n_fail++; $display("FAIL sticky_hold: got %b expected 1", unf_o[0]); end
`endif
  endtask

  task automatic test_random();
    idle(); reset_i = 1; max_i = 9; tick();
    for (int i = 0; i < 600; i++) begin
      reset_i = ($urandom_range(0, 99) < 2);
      load_i  = ($urandom_range(0, 99) < 8);
      clear_i = ($urandom_range(0, 99) < 15);
      en_i    = ($urandom_range(0, 99) < 85);
      up_i    = 1'($urandom); down_i = 1'($urandom);
      step_i  = 4'($urandom);
      load_val_i = 8'($urandom);
      if ($urandom_range(0, 99) < 6)
        max_i = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 20)) : 8'($urandom);
      tick();
      for (int m = 0; m < 2; m++) begin
        n_chk++;
        if (int'(cnt_o[m]) !== m_cnt[m] || int'(evt_o[m]) !== m_evt[m] ||
            amax_o[m] !== (m_cnt[m] == int'(max_i)) || azero_o[m] !== (m_cnt[m] == 0)) begin
          n_fail++;
          $display("FAIL rand[%0d] mode %0d: got cnt %0d evt %b expected cnt %0d evt %0d (max %0d)",
                   i, m, cnt_o[m], evt_o[m], m_cnt[m], m_evt[m], max_i);
        end
`ifdef COUNTER_UPDOWN_MOD_STICKY_EN
        n_chk++;
        if (int'(ovf_o[m]) !== m_ovf[m] || int'(unf_o[m]) !== m_unf[m]) begin
          n_fail++;
          $display("FAIL rand_sticky[%0d] mode %0d: got %b/%b expected %0d/%0d", i, m, ovf_o[m], unf_o[m], m_ovf[m], m_unf[m]);
        end
`endif
      end
    end
  endtask

  initial begin
    idle(); max_i = 9;
    @(posedge clk_i); #1;
    test_reset();
    test_wrap();
    test_saturate();
    test_load();
    test_fold();
    test_max_zero();
    test_sticky();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
